// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: load/store unit bridging the execute stage to a word-wide data bus.
// Each accepted request becomes one word-aligned bus transaction with byte strobes.
// Loads return sign/zero-extended data on dm.
// Optional bus-ack watchdog: define LSU_TIMEOUT_EN to enable (limit TIMEOUT_CYCLES).
module lsu_bus_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] dm,
    output logic        lsu_done,
    output logic        access_err
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e      state_q;
    logic        ex_ready_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_wstrb_q;
    logic [31:0] bus_wdata_q;
    logic [31:0] dm_q;
    logic        lsu_done_q;
    logic        access_err_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        is_load_q;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    logic [CntW-1:0] cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    logic        accept;
    logic        fault;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_ext;

    // Request decode: acceptance, fault detection and store lane placement.
    always_comb begin
        accept = ex_valid & ex_ready_q & (ex_mem_rd | ex_mem_wr);
        fault  = ex_mem_rd & ex_mem_wr;
        if (ex_mem_rd && !(ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) begin
            fault = 1'b1;
        end
        if (ex_mem_wr && !(ex_funct3 inside {3'b000, 3'b001, 3'b010})) begin
            fault = 1'b1;
        end
        if (ex_funct3[1:0] == 2'b01 && ex_addr[0]) begin
            fault = 1'b1;
        end
        if (ex_funct3[1:0] == 2'b10 && ex_addr[1:0] != 2'b00) begin
            fault = 1'b1;
        end
        case (ex_funct3[1:0])
            2'b00: begin
                st_wstrb = 4'b0001 << ex_addr[1:0];
                st_wdata = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                st_wstrb = ex_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{ex_wdata[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
                st_wdata = ex_wdata;
            end
        endcase
    end

    // Load extension from the latched width code and byte offset.
    always_comb begin
        case (off_q)
            2'd0:    rd_byte = bus_rdata[7:0];
            2'd1:    rd_byte = bus_rdata[15:8];
            2'd2:    rd_byte = bus_rdata[23:16];
            default: rd_byte = bus_rdata[31:24];
        endcase
        rd_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  ld_ext = {24'h0, rd_byte};
            3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  ld_ext = {16'h0, rd_half};
            default: ld_ext = bus_rdata;
        endcase
    end

    // Transaction FSM with registered outputs.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q      <= StIdle;
            ex_ready_q   <= 1'b1;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'h0;
            bus_wstrb_q  <= 4'h0;
            bus_wdata_q  <= 32'h0;
            dm_q         <= 32'h0;
            lsu_done_q   <= 1'b0;
            access_err_q <= 1'b0;
            funct3_q     <= 3'h0;
            off_q        <= 2'h0;
            is_load_q    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        funct3_q   <= ex_funct3;
                        off_q      <= ex_addr[1:0];
                        is_load_q  <= ex_mem_rd;
                        ex_ready_q <= 1'b0;
                        if (fault) begin
                            // Faults skip the bus entirely.
                            state_q      <= StResp;
                            lsu_done_q   <= 1'b1;
                            access_err_q <= 1'b1;
                        end else begin
                            state_q     <= StReq;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= ex_mem_wr;
                            bus_addr_q  <= {ex_addr[31:2], 2'b00};
                            bus_wstrb_q <= ex_mem_wr ? st_wstrb : 4'h0;
                            bus_wdata_q <= ex_mem_wr ? st_wdata : 32'h0;
`ifdef LSU_TIMEOUT_EN
                            cnt_q       <= '0;
`endif
                        end
                    end
                end
                StReq: begin
                    if (bus_ack) begin
                        if (is_load_q) begin
                            dm_q <= ld_ext;
                        end
                        state_q    <= StResp;
                        bus_req_q  <= 1'b0;
                        lsu_done_q <= 1'b1;
`ifdef LSU_TIMEOUT_EN
                    end else if (cnt_q == CntLast) begin
                        state_q      <= StResp;
                        bus_req_q    <= 1'b0;
                        lsu_done_q   <= 1'b1;
                        access_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                StResp: begin
                    state_q      <= StIdle;
                    ex_ready_q   <= 1'b1;
                    lsu_done_q   <= 1'b0;
                    access_err_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ex_ready   = ex_ready_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wstrb  = bus_wstrb_q;
    assign bus_wdata  = bus_wdata_q;
    assign dm         = dm_q;
    assign lsu_done   = lsu_done_q;
    assign access_err = access_err_q;

endmodule
